// File: rtl/capture_ctrl_if.sv
// Bundle of the capture sequencer's register-decode, writer and status signals.
// slave = the sequencer itself, master = whoever drives its inputs.
interface capture_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             sample_tick;
    logic             trig_in;
    logic             stable;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [15:0]      cfg_wdata;
    logic             buf_done;
    logic             mcu_busy;
    logic             cap_start;
    logic             cap_abort;
    logic             buf_swap;
    logic [2:0]       busy_state;
    logic             auto_flag;
    logic [CNT_W-1:0] frame_cnt;

    modport slave (
        input  sample_tick, trig_in, stable, cfg_we, cfg_addr, cfg_wdata,
               buf_done, mcu_busy,
        output cap_start, cap_abort, buf_swap, busy_state, auto_flag, frame_cnt
    );

    modport master (
        output sample_tick, trig_in, stable, cfg_we, cfg_addr, cfg_wdata,
               buf_done, mcu_busy,
        input  cap_start, cap_abort, buf_swap, busy_state, auto_flag, frame_cnt
    );
endinterface

// File: rtl/capture_ctrl.sv
// ADC dual-buffer capture sequencer: decides when a frame starts, enforces
// hold-off between frames and waits for the MCU before swapping buffers.
module capture_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    capture_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_WAIT_READ = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    state_t           state_r;
    logic             arm_en_r;
    logic             single_r;
    logic [1:0]       mode_r;
    logic [CNT_W-1:0] holdoff_r;
    logic [CNT_W-1:0] timeout_r;
    logic [CNT_W-1:0] holdoff_lat_r;
    logic [CNT_W-1:0] timeout_lat_r;
    logic [CNT_W-1:0] cnt_r;
    logic             trig_prev_r;
    logic             cap_start_r;
    logic             cap_abort_r;
    logic             buf_swap_r;
    logic             auto_flag_r;
    logic [CNT_W-1:0] frame_cnt_r;

    logic             edge_s;
    logic             force_s;
    logic [CNT_W-1:0] cnt_inc_s;

    assign force_s   = bus.cfg_we && (bus.cfg_addr == 2'd3);
    assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // Trigger qualification for the selected edge mode, only on sample ticks
    always_comb begin
        edge_s = 1'b0;
        if (bus.sample_tick) begin
            case (mode_r)
                2'b00:   edge_s = bus.trig_in & ~trig_prev_r;
                2'b01:   edge_s = ~bus.trig_in & trig_prev_r;
                2'b10:   edge_s = bus.trig_in ^ trig_prev_r;
                default: edge_s = 1'b1;
            endcase
        end else begin
            edge_s = 1'b0;
        end
    end

    // Register file, sequencer state machine and registered pulse/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            arm_en_r      <= 1'b0;
            single_r      <= 1'b0;
            mode_r        <= 2'b00;
            holdoff_r     <= {CNT_W{1'b0}};
            timeout_r     <= {CNT_W{1'b0}};
            holdoff_lat_r <= {CNT_W{1'b0}};
            timeout_lat_r <= {CNT_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            trig_prev_r   <= 1'b0;
            cap_start_r   <= 1'b0;
            cap_abort_r   <= 1'b0;
            buf_swap_r    <= 1'b0;
            auto_flag_r   <= 1'b0;
            frame_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            cap_start_r <= 1'b0;
            cap_abort_r <= 1'b0;
            buf_swap_r  <= 1'b0;

            if (bus.sample_tick) begin
                trig_prev_r <= bus.trig_in;
            end

            if (bus.cfg_we) begin
                case (bus.cfg_addr)
                    2'd0: begin
                        arm_en_r <= bus.cfg_wdata[0];
                        single_r <= bus.cfg_wdata[1];
                        mode_r   <= bus.cfg_wdata[3:2];
                    end
                    2'd1:    holdoff_r <= bus.cfg_wdata[CNT_W-1:0];
                    2'd2:    timeout_r <= bus.cfg_wdata[CNT_W-1:0];
                    default: ;
                endcase
            end

            // Loss of stable beats every other event, including config-driven exits
            if ((state_r != ST_IDLE) && !bus.stable) begin
                state_r     <= ST_IDLE;
                cap_abort_r <= (state_r == ST_CAPTURE);
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (arm_en_r && bus.stable) begin
                            state_r       <= ST_ARMED;
                            timeout_lat_r <= timeout_r;
                        end
                    end
                    ST_ARMED: begin
                        if (!arm_en_r) begin
                            state_r <= ST_IDLE;
                        end else if (edge_s || force_s) begin
                            state_r     <= ST_CAPTURE;
                            cap_start_r <= 1'b1;
                            auto_flag_r <= ~edge_s;
                        end else if (bus.sample_tick && (timeout_lat_r != {CNT_W{1'b0}})) begin
                            if (cnt_inc_s == timeout_lat_r) begin
                                state_r     <= ST_CAPTURE;
                                cap_start_r <= 1'b1;
                                auto_flag_r <= 1'b1;
                            end else begin
                                cnt_r <= cnt_inc_s;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (bus.buf_done) begin
                            state_r <= ST_WAIT_READ;
                        end
                    end
                    ST_WAIT_READ: begin
                        if (!bus.mcu_busy) begin
                            buf_swap_r  <= 1'b1;
                            frame_cnt_r <= frame_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            cnt_r       <= {CNT_W{1'b0}};
                            if (single_r) begin
                                arm_en_r <= 1'b0;
                                state_r  <= ST_IDLE;
                            end else if (holdoff_r == {CNT_W{1'b0}}) begin
                                state_r       <= ST_ARMED;
                                timeout_lat_r <= timeout_r;
                            end else begin
                                state_r       <= ST_HOLDOFF;
                                holdoff_lat_r <= holdoff_r;
                            end
                        end
                    end
                    ST_HOLDOFF: begin
                        if (bus.sample_tick) begin
                            if (cnt_inc_s == holdoff_lat_r) begin
                                cnt_r         <= {CNT_W{1'b0}};
                                timeout_lat_r <= timeout_r;
                                state_r       <= arm_en_r ? ST_ARMED : ST_IDLE;
                            end else begin
                                cnt_r <= cnt_inc_s;
                            end
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.cap_start  = cap_start_r;
    assign bus.cap_abort  = cap_abort_r;
    assign bus.buf_swap   = buf_swap_r;
    assign bus.busy_state = state_r;
    assign bus.auto_flag  = auto_flag_r;
    assign bus.frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: trigger modes, timeout, force, hold-off,
// MCU back-pressure, stable abort, single-shot and asynchronous reset.
module tb_capture_ctrl;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   swap_seen;

    capture_ctrl_if #(.CNT_W(16)) bus ();

    capture_ctrl #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.sample_tick = 1'b1;
        cyc();
        bus.sample_tick = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [15:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        cyc();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic done_pulse();
        bus.buf_done = 1'b1;
        cyc();
        bus.buf_done = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        bus.sample_tick = 1'b0;
        bus.trig_in     = 1'b0;
        bus.stable      = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = 2'd0;
        bus.cfg_wdata   = 16'd0;
        bus.buf_done    = 1'b0;
        bus.mcu_busy    = 1'b0;
        cyc();
        cyc();
        chk("rst_state", {29'd0, bus.busy_state}, 32'd0);
        chk("rst_frame", {16'd0, bus.frame_cnt}, 32'd0);
        chk("rst_pulses", {29'd0, bus.cap_start, bus.cap_abort, bus.buf_swap}, 32'd0);
        chk("rst_auto", {31'd0, bus.auto_flag}, 32'd0);
        rst_n = 1'b1;
        bus.stable = 1'b1;
        cyc();

        // Rising edge trigger, full frame with immediate swap
        cfg_write(2'd0, 16'h0001);
        cyc();
        chk("armed", {29'd0, bus.busy_state}, 32'd1);
        tick();
        chk("no_edge", {31'd0, bus.cap_start}, 32'd0);
        bus.trig_in = 1'b1;
        tick();
        chk("rise_start", {31'd0, bus.cap_start}, 32'd1);
        chk("rise_state", {29'd0, bus.busy_state}, 32'd2);
        chk("rise_auto", {31'd0, bus.auto_flag}, 32'd0);
        cyc();
        chk("start_pulse_1clk", {31'd0, bus.cap_start}, 32'd0);
        done_pulse();
        chk("wait_read", {29'd0, bus.busy_state}, 32'd3);
        cyc();
        chk("swap1", {31'd0, bus.buf_swap}, 32'd1);
        chk("frame1", {16'd0, bus.frame_cnt}, 32'd1);
        chk("rearm1", {29'd0, bus.busy_state}, 32'd1);
        done_pulse();
        chk("done_ignored", {29'd0, bus.busy_state}, 32'd1);
        chk("swap_pulse_1clk", {31'd0, bus.buf_swap}, 32'd0);

        // Falling mode, timeout 5 with trig held high
        cfg_write(2'd0, 16'h0004);
        cfg_write(2'd2, 16'd5);
        cfg_write(2'd0, 16'h0005);
        cyc();
        chk("armed_to", {29'd0, bus.busy_state}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("to_4th_tick", {30'd0, bus.cap_start, bus.busy_state == 3'd1}, 32'd1);
        tick();
        chk("to_start", {31'd0, bus.cap_start}, 32'd1);
        chk("to_auto", {31'd0, bus.auto_flag}, 32'd1);

        // MCU holds the idle buffer for 100 clocks
        bus.mcu_busy = 1'b1;
        done_pulse();
        swap_seen = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (bus.buf_swap) swap_seen++;
        end
        chk("busy_no_swap", swap_seen, 32'd0);
        chk("busy_waiting", {29'd0, bus.busy_state}, 32'd3);
        bus.mcu_busy = 1'b0;
        cyc();
        chk("swap2", {31'd0, bus.buf_swap}, 32'd1);
        chk("frame2", {16'd0, bus.frame_cnt}, 32'd2);
        cyc();
        chk("swap2_once", {31'd0, bus.buf_swap}, 32'd0);

        // Hold-off of 3 samples after a forced frame
        cfg_write(2'd1, 16'd3);
        cfg_write(2'd3, 16'd0);
        chk("force_start", {31'd0, bus.cap_start}, 32'd1);
        chk("force_auto", {31'd0, bus.auto_flag}, 32'd1);
        done_pulse();
        cyc();
        chk("frame3", {16'd0, bus.frame_cnt}, 32'd3);
        chk("holdoff_enter", {29'd0, bus.busy_state}, 32'd4);
        tick();
        chk("holdoff_t1", {29'd0, bus.busy_state}, 32'd4);
        tick();
        chk("holdoff_t2", {29'd0, bus.busy_state}, 32'd4);
        tick();
        chk("holdoff_t3", {29'd0, bus.busy_state}, 32'd1);

        // Falling edge capture, then stable drop aborts it
        bus.trig_in = 1'b0;
        tick();
        chk("fall_start", {31'd0, bus.cap_start}, 32'd1);
        chk("fall_auto", {31'd0, bus.auto_flag}, 32'd0);
        bus.stable = 1'b0;
        cyc();
        chk("abort_pulse", {31'd0, bus.cap_abort}, 32'd1);
        chk("abort_idle", {29'd0, bus.busy_state}, 32'd0);
        chk("abort_frame", {16'd0, bus.frame_cnt}, 32'd3);
        cyc();
        chk("abort_1clk", {31'd0, bus.cap_abort}, 32'd0);
        bus.stable = 1'b1;
        cyc();
        chk("rearm_stable", {29'd0, bus.busy_state}, 32'd1);
        bus.stable = 1'b0;
        cyc();
        chk("armed_drop_noabort", {29'd0, bus.cap_abort, bus.busy_state[1:0]}, 32'd0);
        bus.stable = 1'b1;
        cyc();

        // Single shot via force
        cfg_write(2'd0, 16'h0007);
        cfg_write(2'd3, 16'd0);
        chk("single_start", {29'd0, bus.busy_state}, 32'd2);
        done_pulse();
        cyc();
        chk("single_swap", {31'd0, bus.buf_swap}, 32'd1);
        chk("single_frame", {16'd0, bus.frame_cnt}, 32'd4);
        chk("single_idle", {29'd0, bus.busy_state}, 32'd0);
        cyc();
        cyc();
        cyc();
        chk("single_disarmed", {29'd0, bus.busy_state}, 32'd0);

        // Asynchronous reset in the middle of a capture
        cfg_write(2'd0, 16'h0005);
        cyc();
        cfg_write(2'd3, 16'd0);
        chk("pre_rst_capture", {29'd0, bus.busy_state}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", {29'd0, bus.busy_state}, 32'd0);
        chk("arst_frame", {16'd0, bus.frame_cnt}, 32'd0);
        chk("arst_outs", {28'd0, bus.cap_start, bus.cap_abort, bus.buf_swap, bus.auto_flag}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_abort", {31'd0, bus.cap_abort}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Sequencer for the ADC dual-buffer capture path. Sits between the FSMC register decode and the dual-buffer writer: it decimates nothing itself but decides *when* a frame starts (trigger mode, auto-timeout, force), enforces hold-off between frames, waits for the MCU to release the buffer before swapping, and exposes status. All logic runs in the system clock domain; every input is already synchronous to clk.

## Interface
- CNT_W, 16, width of hold-off / timeout / frame counters
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-clk pulse per ADC sample (adc_clk rising edge, clk domain)
- trig_in  in  1  synchronized comparator square wave
- stable  in  1  ADC-stable qualifier; low aborts everything
- cfg_we  in  1  one-clk register write strobe
- cfg_addr  in  2  register select
- cfg_wdata  in  16  register write data
- buf_done  in  1  one-clk pulse: writer filled the active buffer
- mcu_busy  in  1  MCU currently reading the idle buffer
- cap_start  out  1  one-clk pulse: writer resets pointer and begins filling
- cap_abort  out  1  one-clk pulse: writer discards partial frame
- buf_swap  out  1  one-clk pulse: writer toggles active buffer
- busy_state  out  3  current state encoding (IDLE=0, ARMED=1, CAPTURE=2, WAIT_READ=3, HOLDOFF=4)
- auto_flag  out  1  last frame started by timeout/force rather than trigger
- frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W

## Operation
- Registers: addr0 CTRL {bit0 arm_en, bit1 single, bits3:2 mode: 00 rising, 01 falling, 10 either edge, 11 free-run}; addr1 HOLDOFF (samples); addr2 TIMEOUT (samples, 0 = disabled); addr3 any write = force trigger. Reset: all 0.
- Trigger edge detect: trig_prev updates only on sample_tick; edge evaluated only on sample_tick cycles. Free-run: every sample_tick in ARMED is a trigger.
- IDLE: arm_en && stable -> ARMED; wait counter cleared.
- ARMED: on sample_tick, matching edge -> CAPTURE, cap_start, auto_flag=0. Else if TIMEOUT!=0, wait counter increments per sample_tick; reaching TIMEOUT -> CAPTURE, cap_start, auto_flag=1. Force write -> CAPTURE, cap_start, auto_flag=1 (sample_tick not required). arm_en cleared -> IDLE.
- CAPTURE: buf_done -> WAIT_READ.
- WAIT_READ: when mcu_busy low -> buf_swap, frame_cnt+1; if single: clear arm_en, -> IDLE; else HOLDOFF==0 -> ARMED, else -> HOLDOFF.
- HOLDOFF: counter increments per sample_tick; reaching HOLDOFF -> ARMED (IDLE if arm_en now 0).
- !stable in any non-IDLE state -> IDLE next cycle; cap_abort pulses only when leaving CAPTURE. stable has priority over every other event in the same cycle.
- Priority in ARMED same cycle: !stable > arm_en clear > trigger edge > force > timeout.
- HOLDOFF/TIMEOUT values sampled at entry to HOLDOFF/ARMED; writes mid-state take effect next entry.

## Timing
- All outputs registered. Reset: cap_start=cap_abort=buf_swap=0, busy_state=0, auto_flag=0, frame_cnt=0, trig_prev=0.
- cap_start asserts the cycle after the qualifying sample_tick (or force write); busy_state shows CAPTURE the same cycle.
- buf_swap asserts the cycle after the first cycle with WAIT_READ && !mcu_busy; frame_cnt updates same cycle as buf_swap.
- buf_done while not in CAPTURE: ignored. mcu_busy rising in the cycle of swap decision: swap already committed, not withdrawn.
- Counters saturate never exceed compare value; frame_cnt 0xFFFF+1 -> 0.
- Async reset mid-frame: all outputs to reset values immediately; no cap_abort pulse generated.

## Test plan
- Rising mode, arm_en=1, stable=1, trig_in 0->1 at tick N -> cap_start one clk later, auto_flag=0; buf_done, mcu_busy=0 -> buf_swap, frame_cnt=1.
- Falling mode, TIMEOUT=5, trig_in held high -> cap_start after 5th sample_tick in ARMED, auto_flag=1.
- HOLDOFF=3, continuous -> after buf_swap, exactly 3 sample_ticks in state 4 before returning to ARMED.
- mcu_busy=1 for 100 clks after buf_done -> no buf_swap until mcu_busy falls, then one pulse.
- stable drops in CAPTURE -> cap_abort single pulse, busy_state=0, frame_cnt unchanged.
- single=1 with force write -> one frame, arm_en reads 0, busy_state returns 0; reset mid-CAPTURE -> all outputs 0.
